data_write_buffer: RTL and testbench
====================================

DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter OSW, default 3, width of the outstanding-write counter.
REQ-003 SHALL have ports clk (in, 1, sole clock) and resetn (in, 1, reset, asynchronous, active-low).
REQ-004 SHALL have ports cpu_req (in, 1), cpu_wr (in, 1), cpu_size (in, 3), cpu_wstrb (in, 4), cpu_addr (in, 32) and cpu_wdata (in, 32): the CPU-side SRAM-like request.
REQ-005 SHALL have ports cpu_addr_ok (out, 1), cpu_data_ok (out, 1) and cpu_rdata (out, 32): the CPU-side response.
REQ-006 SHALL have ports mem_req (out, 1), mem_wr (out, 1), mem_size (out, 3), mem_wstrb (out, 4), mem_addr (out, 32) and mem_wdata (out, 32): the request to the downstream AXI bridge data port.
REQ-007 SHALL have ports mem_addr_ok (in, 1), mem_data_ok (in, 1) and mem_rdata (in, 32): the downstream response.

Function
REQ-008 SHALL treat a handshake as req&addr_ok in one cycle; each accepted request SHALL receive exactly one data_ok, in order.
REQ-009 SHALL have FSM states IDLE, RD_REQ, RD_WAIT and RD_RESP.
REQ-010 SHALL accept a store (cpu_addr_ok=1) iff cpu_req&cpu_wr, state=IDLE and the queue is not full; it then pushes {size,wstrb,addr,wdata}.
REQ-011 SHALL assert cpu_data_ok for an accepted store exactly 1 cycle after acceptance, registered, with cpu_rdata don't-care.
REQ-012 SHALL accept a load iff cpu_req&!cpu_wr, state=IDLE, queue empty, outstanding-write count=0 and no store data_ok pending this cycle; then latch size/addr and go to RD_REQ.
REQ-013 SHALL, in RD_REQ, drive mem_req=1, mem_wr=0, latched size/addr and mem_wstrb=0, and go to RD_WAIT on mem_addr_ok.
REQ-014 SHALL, in RD_WAIT, capture mem_rdata into cpu_rdata on mem_data_ok and go to RD_RESP.
REQ-015 SHALL, in RD_RESP, drive cpu_data_ok=1 for 1 cycle, with cpu_rdata valid, and return to IDLE.
REQ-016 SHALL, in IDLE with the queue non-empty and the outstanding count below 2^OSW-1, drive mem_req=1, mem_wr=1 and the head-entry fields.
REQ-017 SHALL, on mem_addr_ok for a write, pop the head and increment the outstanding count.
REQ-018 SHALL decrement the outstanding count on mem_data_ok while in IDLE.
REQ-019 SHALL make a simultaneous increment and decrement leave the count unchanged.
REQ-020 SHALL give draining stores strict priority over loads; a load is held off until the queue is empty and all write data_oks have returned.
REQ-021 SHALL not block pushes while draining; a push and a pop in the same cycle are both honoured and occupancy is unchanged.
REQ-022 SHALL deassert cpu_addr_ok when the queue is full, even if a pop occurs that cycle.
REQ-023 SHALL wrap the queue pointers modulo DEPTH and distinguish full from empty with an extra pointer bit.
REQ-024 SHALL deassert cpu_addr_ok in RD_REQ, RD_WAIT and RD_RESP.
REQ-025 SHALL ignore mem_data_ok in RD_REQ, since the protocol prevents it.
REQ-026 SHALL never have cpu_data_ok sources collide: the store response is issued only from IDLE, and the load response only from RD_RESP.
REQ-027 SHALL drive mem_req=0 and every mem_* output to 0 when neither drain nor read is active.

Reset
REQ-028 SHALL, while resetn=0, immediately force state=IDLE, queue empty, pointers=0, outstanding count=0, cpu_addr_ok=0, cpu_data_ok=0, cpu_rdata=0 and all mem_* outputs=0.
REQ-029 SHALL discard queued stores and in-flight loads on reset mid-operation, with no data_ok for them after reset.
REQ-030 SHALL resume handshakes on the first clock edge after resetn rises.

Verification
REQ-031 SHALL cover a single store: sw addr 0x1000, wdata 0xDEADBEEF, wstrb 0xF -> cpu_data_ok at T+1; mem_req/wr at T+1 with the same fields; count 1 until mem_data_ok.
REQ-032 SHALL cover a full queue: 5 back-to-back stores, mem_addr_ok held 0 -> 4 accepted, cpu_addr_ok=0 on the 5th; 5th accepted the cycle after the first pop.
REQ-033 SHALL cover load-after-store: sw 0x2000 then lw 0x2000, mem write data_ok delayed 5 cycles -> load held until the count returns to 0; mem read issued afterwards; cpu_rdata = mem_rdata, 1 cycle after mem_data_ok.
REQ-034 SHALL cover simultaneous push and pop: queue at 2 entries, a store accepted in the same cycle as the head pops -> occupancy stays 2; data order preserved on mem_wdata.
REQ-035 SHALL cover counter saturation: OSW=3, bvalid withheld, 8 stores -> exactly 7 mem write handshakes, the 8th stays queued until one mem_data_ok.
REQ-036 SHALL cover reset in RD_WAIT: resetn pulsed low -> all outputs 0 at once; a later mem_data_ok produces no cpu_data_ok.

Source files
------------

// File: rtl/data_write_buffer.sv
// data_write_buffer: CPU-side store queue that drains writes ahead of blocking loads to the AXI bridge
module data_write_buffer #(
  parameter int DEPTH = 4,
  parameter int OSW   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [2:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [2:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RD_RESP = 2'd3;

  // queue entry layout: {size[70:68], wstrb[67:64], addr[63:32], wdata[31:0]}
  logic [70:0]    r_q [DEPTH];
  logic [AW:0]    r_wptr, r_rptr;
  logic [OSW-1:0] r_cnt;
  logic [1:0]     r_state, w_nstate;
  logic           r_st_ok;
  logic [31:0]    r_rdata, r_raddr;
  logic [2:0]     r_rsize;
  logic           w_idle, w_empty, w_full, w_st_acc, w_ld_acc;
  logic           w_drain, w_rd, w_pop, w_dec;
  logic [70:0]    w_head;

  assign w_idle  = r_state == IDLE;
  assign w_empty = r_wptr == r_rptr;
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // resetn gates acceptance so addr_ok is low for the whole reset window
  assign w_st_acc = resetn && w_idle && cpu_req && cpu_wr && !w_full;
  assign w_ld_acc = resetn && w_idle && cpu_req && !cpu_wr && w_empty && (r_cnt == '0) && !r_st_ok;
  assign w_drain  = w_idle && !w_empty && (r_cnt != '1);
  assign w_rd     = r_state == RD_REQ;
  assign w_head   = r_q[r_rptr[AW-1:0]];
  assign w_pop    = w_drain && mem_addr_ok;
  assign w_dec    = w_idle && mem_data_ok && (r_cnt != '0);

  assign cpu_addr_ok = w_st_acc || w_ld_acc;
  assign cpu_data_ok = r_st_ok || (r_state == RD_RESP);
  assign cpu_rdata   = r_rdata;
  assign mem_req     = w_drain || w_rd;
  assign mem_wr      = w_drain;
  assign mem_size    = w_drain ? w_head[70:68] : w_rd ? r_rsize : 3'd0;
  assign mem_wstrb   = w_drain ? w_head[67:64] : 4'd0;
  assign mem_addr    = w_drain ? w_head[63:32] : w_rd ? r_raddr : 32'd0;
  assign mem_wdata   = w_drain ? w_head[31:0] : 32'd0;

  // read-path sequencing; mem_data_ok is not looked at in RD_REQ
  always_comb begin
    w_nstate = w_ld_acc ? RD_REQ :
               (w_rd && mem_addr_ok) ? RD_WAIT :
               (r_state == RD_WAIT && mem_data_ok) ? RD_RESP :
               (r_state == RD_RESP) ? IDLE : r_state;
  end

  // queue storage needs no reset: validity is carried by the pointers
  always_ff @(posedge clk) begin
    if (w_st_acc) r_q[r_wptr[AW-1:0]] <= {cpu_size, cpu_wstrb, cpu_addr, cpu_wdata};
  end

  // pointers, outstanding-write count, FSM and response registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_st_ok <= 1'b0;
      r_rdata <= '0;
      r_raddr <= '0;
      r_rsize <= '0;
    end else begin
      r_wptr  <= r_wptr + (AW+1)'(w_st_acc);
      r_rptr  <= r_rptr + (AW+1)'(w_pop);
      r_cnt   <= r_cnt + OSW'(w_pop) - OSW'(w_dec);
      r_state <= w_nstate;
      r_st_ok <= w_st_acc;
      if (w_ld_acc) begin
        r_raddr <= cpu_addr;
        r_rsize <= cpu_size;
      end
      if (r_state == RD_WAIT && mem_data_ok) r_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_write_buffer.sv
// tb_data_write_buffer: directed self-checking bench for data_write_buffer
module tb_data_write_buffer;
  logic        clk = 0, resetn = 0;
  logic        cpu_req = 0, cpu_wr = 0;
  logic [2:0]  cpu_size = 0;
  logic [3:0]  cpu_wstrb = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic [31:0] mem_rdata = 0;
  int checks = 0, errors = 0, hs = 0, h0;
  logic [2:0] occ;

  data_write_buffer #(.DEPTH(4), .OSW(3)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_wstrb(cpu_wstrb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (resetn && mem_req && mem_wr && mem_addr_ok) hs <= hs + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_wr = 1; cpu_addr = a; cpu_wdata = d; cpu_wstrb = 4'hf; cpu_size = 3'd2;
    #1;
  endtask

  initial begin
    cpu_req = 1; cpu_wr = 1;
    #2;
    chk("rst_addr_ok", 32'(cpu_addr_ok), 0);
    chk("rst_data_ok", 32'(cpu_data_ok), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    cpu_req = 0;
    tick;
    resetn = 1;
    // single store
    st(32'h1000, 32'hDEADBEEF);
    chk("sw_addr_ok", 32'(cpu_addr_ok), 1);
    chk("sw_no_memreq", 32'(mem_req), 0);
    tick;
    cpu_req = 0; #1;
    chk("sw_data_ok", 32'(cpu_data_ok), 1);
    chk("sw_mem_req", 32'(mem_req), 1);
    chk("sw_mem_wr", 32'(mem_wr), 1);
    chk("sw_mem_addr", mem_addr, 32'h1000);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_mem_size", 32'(mem_size), 2);
    mem_addr_ok = 1; #1;
    tick;
    mem_addr_ok = 0; #1;
    chk("sw_data_ok_once", 32'(cpu_data_ok), 0);
    chk("sw_drained", 32'(mem_req), 0);
    chk("sw_cnt1", 32'(dut.r_cnt), 1);
    mem_data_ok = 1; #1;
    tick;
    mem_data_ok = 0; #1;
    chk("sw_cnt0", 32'(dut.r_cnt), 0);
    // load after store, write response delayed
    st(32'h2000, 32'h11112222);
    tick;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h2000; cpu_size = 3'd2; mem_addr_ok = 1; #1;
    chk("ls_hold_q", 32'(cpu_addr_ok), 0);
    chk("ls_st_data_ok", 32'(cpu_data_ok), 1);
    chk("ls_wr_addr", mem_addr, 32'h2000);
    tick;
    mem_addr_ok = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("ls_hold_cnt", 32'(cpu_addr_ok), 0);
      tick;
    end
    mem_data_ok = 1; #1;
    chk("ls_hold_last", 32'(cpu_addr_ok), 0);
    tick;
    mem_data_ok = 0; #1;
    chk("ls_accept", 32'(cpu_addr_ok), 1);
    chk("ls_no_memreq", 32'(mem_req), 0);
    tick;
    cpu_wr = 1; #1;
    chk("ls_busy_addr_ok", 32'(cpu_addr_ok), 0);
    chk("rd_mem_req", 32'(mem_req), 1);
    chk("rd_mem_wr", 32'(mem_wr), 0);
    chk("rd_mem_addr", mem_addr, 32'h2000);
    chk("rd_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rd_mem_size", 32'(mem_size), 2);
    cpu_req = 0; mem_addr_ok = 1; #1;
    tick;
    mem_addr_ok = 0; #1;
    chk("rd_wait_memreq", 32'(mem_req), 0);
    tick;
    mem_data_ok = 1; mem_rdata = 32'hCAFEF00D; #1;
    chk("rd_wait_no_ok", 32'(cpu_data_ok), 0);
    tick;
    mem_data_ok = 0; mem_rdata = 0; #1;
    chk("rd_data_ok", 32'(cpu_data_ok), 1);
    chk("rd_rdata", cpu_rdata, 32'hCAFEF00D);
    tick;
    chk("rd_data_ok_once", 32'(cpu_data_ok), 0);
    // full queue
    for (int i = 0; i < 4; i++) begin
      st(32'h3000 + 32'(4*i), 32'hD0 + 32'(i));
      chk("fq_accept", 32'(cpu_addr_ok), 1);
      tick;
    end
    st(32'h3010, 32'hD4);
    chk("fq_full", 32'(cpu_addr_ok), 0);
    chk("fq_head", mem_wdata, 32'hD0);
    mem_addr_ok = 1; #1;
    chk("fq_full_pop", 32'(cpu_addr_ok), 0);
    tick;
    mem_addr_ok = 0; #1;
    chk("fq_5th_ok", 32'(cpu_addr_ok), 1);
    tick;
    cpu_req = 0; mem_addr_ok = 1; #1;
    for (int k = 1; k < 5; k++) begin
      chk("fq_order", mem_wdata, 32'hD0 + 32'(k));
      tick;
    end
    mem_addr_ok = 0; #1;
    chk("fq_empty", 32'(mem_req), 0);
    chk("fq_cnt", 32'(dut.r_cnt), 5);
    mem_data_ok = 1; #1;
    for (int k = 0; k < 5; k++) tick;
    mem_data_ok = 0; #1;
    chk("fq_cnt0", 32'(dut.r_cnt), 0);
    // simultaneous push and pop
    st(32'h4000, 32'hE0); tick;
    st(32'h4004, 32'hE1); tick;
    st(32'h4008, 32'hE2);
    mem_addr_ok = 1; #1;
    chk("pp_accept", 32'(cpu_addr_ok), 1);
    chk("pp_head", mem_wdata, 32'hE0);
    tick;
    cpu_req = 0; #1;
    occ = dut.r_wptr - dut.r_rptr;
    chk("pp_occ", 32'(occ), 2);
    chk("pp_e1", mem_wdata, 32'hE1);
    tick;
    chk("pp_e2", mem_wdata, 32'hE2);
    tick;
    mem_addr_ok = 0; #1;
    chk("pp_drained", 32'(mem_req), 0);
    mem_data_ok = 1; #1;
    for (int k = 0; k < 3; k++) tick;
    mem_data_ok = 0; #1;
    // outstanding-count saturation
    h0 = hs;
    mem_addr_ok = 1;
    for (int i = 0; i < 8; i++) begin
      st(32'h5000 + 32'(4*i), 32'h50 + 32'(i));
      chk("sat_accept", 32'(cpu_addr_ok), 1);
      tick;
    end
    cpu_req = 0; #1;
    chk("sat_stall", 32'(mem_req), 0);
    chk("sat_hs7", 32'(hs - h0), 7);
    chk("sat_cnt7", 32'(dut.r_cnt), 7);
    mem_data_ok = 1; #1;
    tick;
    mem_data_ok = 0; #1;
    chk("sat_resume", 32'(mem_req), 1);
    chk("sat_8th", mem_wdata, 32'h57);
    tick;
    mem_addr_ok = 0; #1;
    chk("sat_hs8", 32'(hs - h0), 8);
    mem_data_ok = 1; #1;
    for (int k = 0; k < 7; k++) tick;
    mem_data_ok = 0; #1;
    chk("sat_cnt0", 32'(dut.r_cnt), 0);
    // reset while waiting for read data
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h4000; #1;
    chk("rw_accept", 32'(cpu_addr_ok), 1);
    tick;
    cpu_req = 0; mem_addr_ok = 1; #1;
    tick;
    mem_addr_ok = 0; #1;
    chk("rw_state", 32'(dut.r_state), 2);
    resetn = 0; #1;
    chk("rw_rst_memreq", 32'(mem_req), 0);
    chk("rw_rst_data_ok", 32'(cpu_data_ok), 0);
    chk("rw_rst_rdata", cpu_rdata, 0);
    chk("rw_rst_state", 32'(dut.r_state), 0);
    tick;
    resetn = 1; mem_data_ok = 1; mem_rdata = 32'h12345678; #1;
    tick;
    mem_data_ok = 0; mem_rdata = 0; #1;
    chk("rw_no_data_ok", 32'(cpu_data_ok), 0);
    chk("rw_rdata0", cpu_rdata, 0);
    tick;
    chk("rw_no_data_ok2", 32'(cpu_data_ok), 0);
    // reset with a queued store
    st(32'h6000, 32'h66);
    chk("qs_accept", 32'(cpu_addr_ok), 1);
    tick;
    cpu_req = 0; resetn = 0; #1;
    chk("qs_rst_data_ok", 32'(cpu_data_ok), 0);
    chk("qs_rst_memreq", 32'(mem_req), 0);
    tick;
    resetn = 1; #1;
    chk("qs_discarded", 32'(mem_req), 0);
    // handshakes resume after reset
    st(32'h7000, 32'h77);
    chk("rs_accept", 32'(cpu_addr_ok), 1);
    tick;
    cpu_req = 0; #1;
    chk("rs_data_ok", 32'(cpu_data_ok), 1);
    chk("rs_mem_addr", mem_addr, 32'h7000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
